multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15: maximum consecutive cycles of mem_ready low tolerated in any memory state.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have inputs opcode[6:0] and f3[2:0] from the instruction register, plus zero and lt (signed rs1<rs2) from the ALU, each 1 bit.
REQ-005 SHALL have input mem_ready  1  memory completion for the current request.
REQ-006 SHALL have outputs PC_write, IR_write, reg_write, mem_req, mem_we, adr_src (0=PC, 1=ALU_out), each 1 bit.
REQ-007 SHALL have outputs ALU_src_A[1:0] (00 PC, 01 old_PC, 10 rs1), ALU_src_B[1:0] (00 rs2, 01 imm, 10 const 4), result_src[1:0] (00 ALU_out, 01 mem data, 10 ALU result, 11 imm), and ALU_op[1:0] (00 add, 01 sub, 10 R-type, 11 I-type), which drives ALUDecoder.
REQ-008 SHALL have outputs imm_sel[2:0] (I 000, S 001, B 010, J 011, U 100), halt 1, and mem_timeout 1.

Function
REQ-009 Opcodes: R 0110011, I 0010011, LW 0000011, SW 0100011, B 1100011, JAL 1101111, JALR 1100111, LUI 0110111.
REQ-010 imm_sel SHALL be combinational from opcode in every state; unlisted opcodes give 000.
REQ-011 Any output not named for a state SHALL be 0 in that state; ALU_src and ALU_op default to 00.
REQ-012 FETCH: mem_req=1 and adr_src=0. While mem_ready=0, stay. When mem_ready=1, assert IR_write and PC_write with A=PC, B=4, add, result_src=10, then go to DECODE.
REQ-013 DECODE: compute A=old_PC, B=imm, add into ALU_out. Next state by opcode: R->EXEC_R, I->EXEC_I, LW/SW->MEM_ADDR, B->BRANCH, JAL->JAL, JALR->JALR, LUI->LUI, anything else->HALT.
REQ-014 EXEC_R: A=rs1, B=rs2, ALU_op=10, then go to ALU_WB. EXEC_I: A=rs1, B=imm, ALU_op=11, then go to ALU_WB.
REQ-015 ALU_WB: reg_write=1, result_src=00, then go to FETCH.
REQ-016 MEM_ADDR: A=rs1, B=imm, add. Then go to MEM_READ for LW or MEM_WRITE for SW.
REQ-017 MEM_READ: mem_req=1, adr_src=1; wait for mem_ready, then go to MEM_WB. MEM_WB: reg_write=1, result_src=01, then go to FETCH.
REQ-018 MEM_WRITE: mem_req=1, mem_we=1, adr_src=1; wait for mem_ready, then go to FETCH.
REQ-019 BRANCH: A=rs1, B=rs2, ALU_op=01, result_src=00; PC_write=take, then go to FETCH.
REQ-020 take rules: f3 000 gives zero; 001 gives !zero; 100 gives lt; 101 gives !lt. Any other f3 SHALL go to HALT with PC_write=0.
REQ-021 JAL: PC_write=1 with result_src=00 (target); A=old_PC, B=4, add; then go to ALU_WB, which writes the link value.
REQ-022 JALR: A=rs1, B=imm, add, result_src=10, PC_write=1, then go to JALR_LINK. JALR_LINK: A=old_PC, B=4, add, then go to ALU_WB.
REQ-023 LUI: reg_write=1, result_src=11, then go to FETCH.
REQ-024 A wait counter SHALL increment each cycle mem_ready=0 in FETCH, MEM_READ or MEM_WRITE, and clear on any state change.
REQ-025 When the counter reaches MAX_WAIT with mem_ready still 0: mem_timeout SHALL pulse for exactly one cycle and the state SHALL go to HALT. A mem_ready arriving in that same cycle SHALL take priority, giving normal completion and no timeout.
REQ-026 HALT: halt=1, all enables 0; the state is left only by reset.

Reset
REQ-027 While rst=0: state=FETCH, counter=0, halt=0, mem_timeout=0. All outputs SHALL take their FETCH values, so mem_req=1 from the first cycle after release.
REQ-028 Reset asserted mid-instruction SHALL abort it immediately, with no partial PC_write, reg_write or mem_we.

Structure
REQ-029 A shared package SHALL hold the state enumeration, opcode constants, ALU_op codes, source-select codes and imm_sel codes.
REQ-030 Branch-condition evaluation SHALL be one sub-module, branch_cond (f3, zero, lt -> take, illegal).

Verification
REQ-031 add x3,x1,x2 with mem_ready=1 throughout: states FETCH, DECODE, EXEC_R, ALU_WB; reg_write in cycle 4; next FETCH in cycle 5.
REQ-032 LW with mem_ready delayed 3 cycles in MEM_READ: mem_req and adr_src held 1 for 4 cycles; MEM_WB follows; total 8 cycles.
REQ-033 beq with zero=1 gives PC_write=1 in BRANCH; bne with zero=1 gives PC_write=0; blt with lt=1 gives PC_write=1.
REQ-034 mem_ready stuck 0 in FETCH with MAX_WAIT=15: mem_timeout pulses in exactly one cycle, halt=1 after it; a later mem_ready is ignored.
REQ-035 opcode 1111111 in DECODE: HALT the next cycle. rst low mid-MEM_WRITE: mem_we=0 at once, FETCH on release.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle RISC-V control unit: FSM state
// encoding, opcode constants, ALU operation codes, datapath source-select
// codes and immediate-format codes, plus the opcode -> immediate-format map.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB,
    S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
    S_BRANCH, S_JAL, S_JALR, S_JALR_LINK, S_LUI, S_HALT
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU_OUT = 2'b00;
  localparam logic [1:0] RES_MEM     = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;
  localparam logic [1:0] RES_IMM     = 2'b11;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Immediate format implied by an opcode; unknown opcodes fall back to I.
  function automatic logic [2:0] imm_sel_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_B:    return IMM_B;
      OP_JAL:  return IMM_J;
      OP_LUI:  return IMM_U;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_branch_cond.sv
// Branch-condition evaluation.
//   f3      : branch funct3 field
//   zero/lt : ALU flags from rs1-rs2 (lt is the signed compare)
//   take    : branch condition satisfied (never set for an illegal f3)
//   illegal : f3 is not one of beq/bne/blt/bge
module branch_cond (
  input  logic [2:0] f3,
  input  logic       zero,
  input  logic       lt,
  output logic       take,
  output logic       illegal
);

  always_comb begin
    take    = 1'b0;
    illegal = 1'b0;
    case (f3)
      3'b000:  take = zero;
      3'b001:  take = !zero;
      3'b100:  take = lt;
      3'b101:  take = !lt;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM with memory-wait timeout.
//   clk, rst (async, active-low)
//   opcode, f3            : instruction-register fields
//   zero, lt              : ALU flags
//   mem_ready             : memory completion for the current request
//   PC_write .. ALU_op    : datapath enables and mux selects
//   imm_sel               : immediate format, decoded from opcode in every state
//   halt                  : controller stopped (left only by reset)
//   mem_timeout           : one-cycle pulse when a memory wait exceeds MAX_WAIT
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] f3,
  input  logic       zero,
  input  logic       lt,
  input  logic       mem_ready,
  output logic       PC_write,
  output logic       IR_write,
  output logic       reg_write,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic [1:0] ALU_src_A,
  output logic [1:0] ALU_src_B,
  output logic [1:0] result_src,
  output logic [1:0] ALU_op,
  output logic [2:0] imm_sel,
  output logic       halt,
  output logic       mem_timeout
);

  // Wide enough to hold MAX_WAIT, and never zero-width.
  localparam int CW = $clog2(MAX_WAIT + 2);

  state_t        state, state_next;
  logic [CW-1:0] wait_cnt;
  logic          take, illegal;
  logic          mem_state, timeout_hit, fetch_done;

  branch_cond u_branch_cond (
    .f3      (f3),
    .zero    (zero),
    .lt      (lt),
    .take    (take),
    .illegal (illegal)
  );

  assign mem_state = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
  // mem_ready in the final tolerated cycle wins over the timeout. Reset gates
  // the combinational terms so nothing escapes while rst is held low.
  assign timeout_hit = rst && mem_state && !mem_ready && (wait_cnt == CW'(MAX_WAIT));
  assign fetch_done  = rst && mem_ready;

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:     if (fetch_done) state_next = S_DECODE;
                   else if (timeout_hit) state_next = S_HALT;
      S_DECODE: begin
        case (opcode)
          OP_R:         state_next = S_EXEC_R;
          OP_I:         state_next = S_EXEC_I;
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_B:         state_next = S_BRANCH;
          OP_JAL:       state_next = S_JAL;
          OP_JALR:      state_next = S_JALR;
          OP_LUI:       state_next = S_LUI;
          default:      state_next = S_HALT;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_next = S_ALU_WB;
      S_ALU_WB:    state_next = S_FETCH;
      S_MEM_ADDR:  state_next = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_next = S_MEM_WB;
                   else if (timeout_hit) state_next = S_HALT;
      S_MEM_WB:    state_next = S_FETCH;
      S_MEM_WRITE: if (mem_ready) state_next = S_FETCH;
                   else if (timeout_hit) state_next = S_HALT;
      S_BRANCH:    state_next = illegal ? S_HALT : S_FETCH;
      S_JAL:       state_next = S_ALU_WB;
      S_JALR:      state_next = S_JALR_LINK;
      S_JALR_LINK: state_next = S_ALU_WB;
      S_LUI:       state_next = S_FETCH;
      default:     state_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if (mem_state && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    PC_write   = 1'b0;
    IR_write   = 1'b0;
    reg_write  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ALU_src_A  = SRC_A_PC;
    ALU_src_B  = SRC_B_RS2;
    result_src = RES_ALU_OUT;
    ALU_op     = ALU_ADD;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (fetch_done) begin
          IR_write   = 1'b1;
          PC_write   = 1'b1;
          ALU_src_B  = SRC_B_FOUR;
          result_src = RES_ALU;
        end
      end
      S_DECODE: begin
        ALU_src_A = SRC_A_OLD_PC;
        ALU_src_B = SRC_B_IMM;
      end
      S_EXEC_R: begin
        ALU_src_A = SRC_A_RS1;
        ALU_op    = ALU_RTYPE;
      end
      S_EXEC_I: begin
        ALU_src_A = SRC_A_RS1;
        ALU_src_B = SRC_B_IMM;
        ALU_op    = ALU_ITYPE;
      end
      S_ALU_WB: reg_write = 1'b1;
      S_MEM_ADDR: begin
        ALU_src_A = SRC_A_RS1;
        ALU_src_B = SRC_B_IMM;
      end
      S_MEM_READ: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        result_src = RES_MEM;
      end
      S_MEM_WRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
      end
      S_BRANCH: begin
        ALU_src_A = SRC_A_RS1;
        ALU_op    = ALU_SUB;
        PC_write  = take;
      end
      S_JAL: begin
        PC_write  = 1'b1;
        ALU_src_A = SRC_A_OLD_PC;
        ALU_src_B = SRC_B_FOUR;
      end
      S_JALR: begin
        ALU_src_A  = SRC_A_RS1;
        ALU_src_B  = SRC_B_IMM;
        result_src = RES_ALU;
        PC_write   = 1'b1;
      end
      S_JALR_LINK: begin
        ALU_src_A = SRC_A_OLD_PC;
        ALU_src_B = SRC_B_FOUR;
      end
      S_LUI: begin
        reg_write  = 1'b1;
        result_src = RES_IMM;
      end
      default: ;
    endcase
  end

  assign imm_sel     = imm_sel_of(opcode);
  assign halt        = (state == S_HALT);
  assign mem_timeout = timeout_hit;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller. Outputs are packed
// into one signature {PC_write, IR_write, reg_write, mem_req, mem_we, adr_src,
// ALU_src_A, ALU_src_B, result_src, ALU_op, halt, mem_timeout} and compared
// against hand-written per-state values one cycle at a time.
module tb_multicycle_controller;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_B = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_BAD = 7'b1111111;

  //                                      PIRMWA  A B R O  HT
  localparam logic [15:0] SIG_FETCH_WAIT = 16'b000100_00000000_00;
  localparam logic [15:0] SIG_FETCH_DONE = 16'b110100_00101000_00;
  localparam logic [15:0] SIG_DECODE     = 16'b000000_01010000_00;
  localparam logic [15:0] SIG_EXEC_R     = 16'b000000_10000010_00;
  localparam logic [15:0] SIG_EXEC_I     = 16'b000000_10010011_00;
  localparam logic [15:0] SIG_ALU_WB     = 16'b001000_00000000_00;
  localparam logic [15:0] SIG_MEM_ADDR   = 16'b000000_10010000_00;
  localparam logic [15:0] SIG_MEM_READ   = 16'b000101_00000000_00;
  localparam logic [15:0] SIG_MEM_WB     = 16'b001000_00000100_00;
  localparam logic [15:0] SIG_MEM_WRITE  = 16'b000111_00000000_00;
  localparam logic [15:0] SIG_BR_TAKE    = 16'b100000_10000001_00;
  localparam logic [15:0] SIG_BR_NOT     = 16'b000000_10000001_00;
  localparam logic [15:0] SIG_JAL        = 16'b100000_01100000_00;
  localparam logic [15:0] SIG_JALR       = 16'b100000_10011000_00;
  localparam logic [15:0] SIG_JALR_LINK  = 16'b000000_01100000_00;
  localparam logic [15:0] SIG_LUI        = 16'b001000_00001100_00;
  localparam logic [15:0] SIG_HALT       = 16'b000000_00000000_10;
  localparam logic [15:0] SIG_TIMEOUT    = 16'b000100_00000000_01;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] f3 = '0;
  logic       zero = 1'b0, lt = 1'b0, mem_ready = 1'b0;
  logic       PC_write, IR_write, reg_write, mem_req, mem_we, adr_src, halt, mem_timeout;
  logic [1:0] ALU_src_A, ALU_src_B, result_src, ALU_op;
  logic [2:0] imm_sel;
  logic [15:0] sig;
  int checks = 0;
  int passed = 0;

  multicycle_controller #(.MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .f3(f3), .zero(zero), .lt(lt),
    .mem_ready(mem_ready), .PC_write(PC_write), .IR_write(IR_write),
    .reg_write(reg_write), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
    .ALU_src_A(ALU_src_A), .ALU_src_B(ALU_src_B), .result_src(result_src),
    .ALU_op(ALU_op), .imm_sel(imm_sel), .halt(halt), .mem_timeout(mem_timeout)
  );

  assign sig = {PC_write, IR_write, reg_write, mem_req, mem_we, adr_src,
                ALU_src_A, ALU_src_B, result_src, ALU_op, halt, mem_timeout};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (sig !== SIG_FETCH_WAIT) $display("FAIL reset_outputs: sig=%b expected %b", sig, SIG_FETCH_WAIT);
    else passed++;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (mem_req !== 1'b1 || halt !== 1'b0) $display("FAIL reset_release: mem_req=%b halt=%b expected 1 0", mem_req, halt);
    else passed++;
  endtask

  task automatic test_imm_sel();
    logic [6:0] ops [9];
    logic [2:0] exp [9];
    ops = '{OP_R, OP_I, OP_LW, OP_SW, OP_B, OP_JAL, OP_JALR, OP_LUI, OP_BAD};
    exp = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b010, 3'b011, 3'b000, 3'b100, 3'b000};
    mem_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      opcode = ops[i];
      #1;
      checks++;
      if (imm_sel !== exp[i]) $display("FAIL imm_sel op=%b: got %b expected %b", ops[i], imm_sel, exp[i]);
      else passed++;
      tick();
    end
  endtask

  // add then addi, mem_ready=1 throughout: 4 cycles each, FETCH again in cycle 5.
  task automatic test_alu();
    logic [15:0] exp [9];
    logic [6:0]  ops [9];
    exp = '{SIG_FETCH_DONE, SIG_DECODE, SIG_EXEC_R, SIG_ALU_WB,
            SIG_FETCH_DONE, SIG_DECODE, SIG_EXEC_I, SIG_ALU_WB, SIG_FETCH_WAIT};
    ops = '{OP_R, OP_R, OP_R, OP_R, OP_I, OP_I, OP_I, OP_I, OP_I};
    for (int i = 0; i < 9; i++) begin
      opcode = ops[i];
      mem_ready = (i < 8);
      #1;
      checks++;
      if (sig !== exp[i]) $display("FAIL alu cycle %0d: sig=%b expected %b", i, sig, exp[i]);
      else passed++;
      if (i < 8) tick();
    end
  endtask

  // lw with 3 wait cycles in MEM_READ (8 cycles total), then sw with 1 wait.
  task automatic test_mem();
    logic [15:0] exp [14];
    logic [6:0]  ops [14];
    logic        rdy [14];
    exp = '{SIG_FETCH_DONE, SIG_DECODE, SIG_MEM_ADDR, SIG_MEM_READ, SIG_MEM_READ,
            SIG_MEM_READ, SIG_MEM_READ, SIG_MEM_WB,
            SIG_FETCH_DONE, SIG_DECODE, SIG_MEM_ADDR, SIG_MEM_WRITE, SIG_MEM_WRITE,
            SIG_FETCH_WAIT};
    ops = '{OP_LW, OP_LW, OP_LW, OP_LW, OP_LW, OP_LW, OP_LW, OP_LW,
            OP_SW, OP_SW, OP_SW, OP_SW, OP_SW, OP_SW};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
            1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 14; i++) begin
      opcode = ops[i];
      mem_ready = rdy[i];
      #1;
      checks++;
      if (sig !== exp[i]) $display("FAIL mem cycle %0d: sig=%b expected %b", i, sig, exp[i]);
      else passed++;
      if (i < 13) tick();
    end
  endtask

  // beq z=1 taken, bne z=1 not, blt lt=1 taken, bge lt=1 not.
  task automatic test_branch();
    logic [2:0]  f3s [4];
    logic        zs [4];
    logic        lts [4];
    logic [15:0] br [4];
    f3s = '{3'b000, 3'b001, 3'b100, 3'b101};
    zs  = '{1'b1, 1'b1, 1'b0, 1'b0};
    lts = '{1'b0, 1'b0, 1'b1, 1'b1};
    br  = '{SIG_BR_TAKE, SIG_BR_NOT, SIG_BR_TAKE, SIG_BR_NOT};
    opcode = OP_B;
    for (int b = 0; b < 4; b++) begin
      f3 = f3s[b];
      zero = zs[b];
      lt = lts[b];
      mem_ready = 1'b1;
      #1;
      tick();
      #1;
      tick();
      #1;
      checks++;
      if (sig !== br[b]) $display("FAIL branch f3=%b: sig=%b expected %b", f3s[b], sig, br[b]);
      else passed++;
      tick();
    end
    mem_ready = 1'b0;
    #1;
    checks++;
    if (sig !== SIG_FETCH_WAIT) $display("FAIL branch_return: sig=%b expected %b", sig, SIG_FETCH_WAIT);
    else passed++;
  endtask

  // jal (4 cycles), jalr (5 cycles), lui (3 cycles).
  task automatic test_jumps();
    logic [15:0] exp [13];
    logic [6:0]  ops [13];
    exp = '{SIG_FETCH_DONE, SIG_DECODE, SIG_JAL, SIG_ALU_WB,
            SIG_FETCH_DONE, SIG_DECODE, SIG_JALR, SIG_JALR_LINK, SIG_ALU_WB,
            SIG_FETCH_DONE, SIG_DECODE, SIG_LUI, SIG_FETCH_WAIT};
    ops = '{OP_JAL, OP_JAL, OP_JAL, OP_JAL, OP_JALR, OP_JALR, OP_JALR, OP_JALR,
            OP_JALR, OP_LUI, OP_LUI, OP_LUI, OP_LUI};
    for (int i = 0; i < 13; i++) begin
      opcode = ops[i];
      mem_ready = (i < 12);
      #1;
      checks++;
      if (sig !== exp[i]) $display("FAIL jumps cycle %0d: sig=%b expected %b", i, sig, exp[i]);
      else passed++;
      if (i < 12) tick();
    end
  endtask

  task automatic test_reset_mid_write();
    opcode = OP_SW;
    mem_ready = 1'b1;
    #1; tick(); #1; tick(); #1; tick();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (sig !== SIG_MEM_WRITE) $display("FAIL pre_abort: sig=%b expected %b", sig, SIG_MEM_WRITE);
    else passed++;
    rst = 1'b0;
    #1;
    checks++;
    if (mem_we !== 1'b0 || sig !== SIG_FETCH_WAIT) $display("FAIL abort_write: mem_we=%b sig=%b expected 0 %b", mem_we, sig, SIG_FETCH_WAIT);
    else passed++;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (sig !== SIG_FETCH_WAIT) $display("FAIL abort_release: sig=%b expected %b", sig, SIG_FETCH_WAIT);
    else passed++;
  endtask

  task automatic test_illegal();
    logic [6:0]  ops [2];
    logic [15:0] third [2];
    string       nm [2];
    ops = '{OP_B, OP_BAD};
    third = '{SIG_BR_NOT, SIG_HALT};
    nm = '{"illegal_f3", "illegal_opcode"};
    for (int t = 0; t < 2; t++) begin
      apply_reset();
      opcode = ops[t];
      f3 = 3'b010;
      zero = 1'b1;
      lt = 1'b1;
      mem_ready = 1'b1;
      #1; tick(); #1; tick(); #1;
      checks++;
      if (sig !== third[t]) $display("FAIL %s step3: sig=%b expected %b", nm[t], sig, third[t]);
      else passed++;
      tick(); tick();
      #1;
      checks++;
      if (sig !== SIG_HALT) $display("FAIL %s halted: sig=%b expected %b", nm[t], sig, SIG_HALT);
      else passed++;
    end
    f3 = 3'b000;
    zero = 1'b0;
    lt = 1'b0;
  endtask

  task automatic test_timeout();
    int first = -1;
    int pulses = 0;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      mem_ready = 1'b0;
      #1;
      if (mem_timeout === 1'b1) begin
        pulses++;
        if (first < 0) first = i;
        checks++;
        if (sig !== SIG_TIMEOUT) $display("FAIL timeout_sig: sig=%b expected %b", sig, SIG_TIMEOUT);
        else passed++;
      end
      tick();
    end
    checks++;
    if (first !== 15) $display("FAIL timeout_cycle: got %0d expected 15", first);
    else passed++;
    checks++;
    if (pulses !== 1) $display("FAIL timeout_pulses: got %0d expected 1", pulses);
    else passed++;
    mem_ready = 1'b1;
    tick(); tick();
    checks++;
    if (sig !== SIG_HALT) $display("FAIL timeout_sticky: sig=%b expected %b", sig, SIG_HALT);
    else passed++;
  endtask

  // mem_ready in the last tolerated cycle completes normally.
  task automatic test_timeout_priority();
    apply_reset();
    opcode = OP_LUI;
    for (int i = 0; i < 15; i++) begin
      mem_ready = 1'b0;
      tick();
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (sig !== SIG_FETCH_DONE) $display("FAIL priority_edge: sig=%b expected %b", sig, SIG_FETCH_DONE);
    else passed++;
    tick();
    checks++;
    if (sig !== SIG_DECODE) $display("FAIL priority_next: sig=%b expected %b", sig, SIG_DECODE);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_imm_sel();
    test_alu();
    test_mem();
    test_branch();
    test_jumps();
    test_reset_mid_write();
    test_illegal();
    test_timeout();
    test_timeout_priority();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
